// File: rtl/movement_arbiter.sv
// movement_arbiter: checks requested piece cells against the locked board,
// answers commit/decline/steal and writes the piece into the board on a lock.
module movement_arbiter #(
  parameter int BOARD_H = 20,
  parameter int BOARD_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        movement_request,
  input  logic        movement_intent,
  input  logic [4:0]  P1blk_v,
  input  logic [4:0]  P2blk_v,
  input  logic [4:0]  P3blk_v,
  input  logic [4:0]  P4blk_v,
  input  logic [4:0]  P1blk_h,
  input  logic [4:0]  P2blk_h,
  input  logic [4:0]  P3blk_h,
  input  logic [4:0]  P4blk_h,
  input  logic [2:0]  volatile_blk_color,
  output logic        movement_commit,
  output logic        movement_declined,
  output logic        movement_steal,
  output logic [4:0]  board_raddr_h,
  output logic [4:0]  board_raddr_v,
  input  logic [2:0]  board_rdata,
  output logic        board_we,
  output logic [4:0]  board_waddr_h,
  output logic [4:0]  board_waddr_v,
  output logic [2:0]  board_wdata,
  output logic        lock_pulse,
  output logic [15:0] piece_count,
  output logic        arb_busy
);

  typedef enum logic [2:0] {
    IDLE, CHECK, DECIDE, COMMIT,
    DECLINE, LOCK, STEAL, WAIT_DROP
  } state_t;

  state_t          state;
  logic [3:0][4:0] in_h;
  logic [3:0][4:0] in_v;
  logic [3:0][4:0] lat_h;
  logic [3:0][4:0] lat_v;
  logic [3:0]      in_oob;
  logic [3:0]      oob;
  logic [3:0]      wr_ok;
  logic [2:0]      lat_color;
  logic            lat_intent;
  logic            hit;
  logic [2:0]      idx;
  logic [1:0]      nxt;
  logic [1:0]      prv;

  assign in_h = {P4blk_h, P3blk_h, P2blk_h, P1blk_h};
  assign in_v = {P4blk_v, P3blk_v, P2blk_v, P1blk_v};
  assign nxt  = idx[1:0] + 2'd1;
  assign prv  = idx[1:0] - 2'd1;

  // Bounds of the incoming cells and write legality of the shifted cells
  always_comb begin
    in_oob = '0;
    wr_ok  = '0;
    for (int k = 0; k < 4; k++) begin
      in_oob[k] = (in_h[k] >= 5'(BOARD_H)) |
                  (in_v[k] >= 5'(BOARD_W));
      wr_ok[k]  = (lat_h[k] != 5'd0) &&
                  ((lat_h[k] - 5'd1) < 5'(BOARD_H)) &&
                  (lat_v[k] < 5'(BOARD_W));
    end
  end

  // Arbitration state machine with registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= IDLE;
      lat_h             <= '0;
      lat_v             <= '0;
      oob               <= '0;
      lat_color         <= '0;
      lat_intent        <= 1'b0;
      hit               <= 1'b0;
      idx               <= '0;
      movement_commit   <= 1'b0;
      movement_declined <= 1'b0;
      movement_steal    <= 1'b0;
      board_raddr_h     <= '0;
      board_raddr_v     <= '0;
      board_we          <= 1'b0;
      board_waddr_h     <= '0;
      board_waddr_v     <= '0;
      board_wdata       <= '0;
      lock_pulse        <= 1'b0;
      piece_count       <= '0;
      arb_busy          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (movement_request) begin
            lat_h         <= in_h;
            lat_v         <= in_v;
            oob           <= in_oob;
            lat_color     <= volatile_blk_color;
            lat_intent    <= movement_intent;
            hit           <= 1'b0;
            idx           <= '0;
            board_raddr_h <= in_h[0];
            board_raddr_v <= in_v[0];
            arb_busy      <= 1'b1;
            state         <= CHECK;
          end
        end
        CHECK: begin
          if (idx != 3'd0)
            hit <= hit | ((board_rdata != 3'd0) & ~oob[prv]);
          if (idx < 3'd3) begin
            board_raddr_h <= lat_h[nxt];
            board_raddr_v <= lat_v[nxt];
          end
          if (idx == 3'd4) begin
            state <= DECIDE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        DECIDE: begin
          if (!(hit | (|oob))) begin
            movement_commit <= 1'b1;
            state           <= COMMIT;
          end else if (lat_intent) begin
            movement_declined <= 1'b1;
            state             <= DECLINE;
          end else begin
            idx           <= '0;
            board_we      <= wr_ok[0];
            board_waddr_h <= lat_h[0] - 5'd1;
            board_waddr_v <= lat_v[0];
            board_wdata   <= lat_color;
            state         <= LOCK;
          end
        end
        COMMIT: begin
          movement_commit <= 1'b0;
          state           <= WAIT_DROP;
        end
        DECLINE: begin
          if (!movement_request) begin
            movement_declined <= 1'b0;
            arb_busy          <= 1'b0;
            state             <= IDLE;
          end
        end
        LOCK: begin
          if (idx == 3'd3) begin
            board_we       <= 1'b0;
            piece_count    <= piece_count + 16'd1;
            lock_pulse     <= 1'b1;
            movement_steal <= 1'b1;
            state          <= STEAL;
          end else begin
            idx           <= idx + 3'd1;
            board_we      <= wr_ok[nxt];
            board_waddr_h <= lat_h[nxt] - 5'd1;
            board_waddr_v <= lat_v[nxt];
          end
        end
        STEAL: begin
          lock_pulse <= 1'b0;
          if (!movement_request) begin
            movement_steal <= 1'b0;
            arb_busy       <= 1'b0;
            state          <= IDLE;
          end
        end
        WAIT_DROP: begin
          if (!movement_request) begin
            arb_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_movement_arbiter.sv
// tb_movement_arbiter: scenario tasks against a board RAM model,
// board writes checked through an expected-write queue.
module tb_movement_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        intent = 1'b0;
  logic [3:0][4:0] ph = '0;
  logic [3:0][4:0] pv = '0;
  logic [2:0]  color = 3'd1;
  logic        commit, declined, steal;
  logic [4:0]  raddr_h, raddr_v;
  logic [2:0]  rdata;
  logic        we;
  logic [4:0]  waddr_h, waddr_v;
  logic [2:0]  wdata;
  logic        lock_pulse;
  logic [15:0] piece_count;
  logic        busy;

  logic [2:0]  mem [32][32];
  logic        clr = 1'b1;
  logic        poke_en = 1'b0;
  logic [4:0]  poke_h = '0;
  logic [4:0]  poke_v = '0;
  logic [2:0]  poke_d = '0;

  logic [12:0] exp_q[$];
  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  movement_arbiter dut (
    .clk(clk), .reset(reset),
    .movement_request(req), .movement_intent(intent),
    .P1blk_v(pv[0]), .P2blk_v(pv[1]),
    .P3blk_v(pv[2]), .P4blk_v(pv[3]),
    .P1blk_h(ph[0]), .P2blk_h(ph[1]),
    .P3blk_h(ph[2]), .P4blk_h(ph[3]),
    .volatile_blk_color(color),
    .movement_commit(commit),
    .movement_declined(declined),
    .movement_steal(steal),
    .board_raddr_h(raddr_h), .board_raddr_v(raddr_v),
    .board_rdata(rdata),
    .board_we(we),
    .board_waddr_h(waddr_h), .board_waddr_v(waddr_v),
    .board_wdata(wdata),
    .lock_pulse(lock_pulse),
    .piece_count(piece_count),
    .arb_busy(busy)
  );

  // board RAM model: registered read, write port from DUT or bench pokes
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 32; i++)
        for (int j = 0; j < 32; j++)
          mem[i][j] <= 3'd0;
    end else if (poke_en) begin
      mem[poke_h][poke_v] <= poke_d;
    end else if (we) begin
      mem[waddr_h][waddr_v] <= wdata;
    end
    rdata <= mem[raddr_h][raddr_v];
  end

  // scoreboard: every board write must match the oldest expected write
  always @(negedge clk) begin
    if (we) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write got h=%0d v=%0d d=%0d want none",
                 waddr_h, waddr_v, wdata);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        if ({waddr_h, waddr_v, wdata} !== e)
          $display("FAIL write got %h want %h",
                   {waddr_h, waddr_v, wdata}, e);
        else
          pass_cnt++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [4:0] h, input logic [4:0] v,
                      input logic [2:0] d);
    poke_h = h; poke_v = v; poke_d = d; poke_en = 1'b1;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic fire(input logic [19:0] hs, input logic [19:0] vs,
                      input logic it, input logic [2:0] c);
    ph = hs; pv = vs; intent = it; color = c;
    req = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b0; clr = 1'b1;
    tick(); tick(); tick();
    total++;
    if ({commit, declined, steal, we, lock_pulse, busy} !== 6'b0 ||
        piece_count !== 16'd0 ||
        {raddr_h, raddr_v, waddr_h, waddr_v, wdata} !== 23'd0) begin
      $display("FAIL reset_outputs got %b pc=%0d want zeros",
               {commit, declined, steal, we, lock_pulse, busy}, piece_count);
    end else pass_cnt++;
    clr = 1'b0; reset = 1'b1;
    tick();
  endtask

  task automatic test_commit;
    fire({5'd9, 5'd8, 5'd7, 5'd6}, {4{5'd5}}, 1'b0, 3'd1);
    for (int n = 1; n <= 10; n++) begin
      logic [3:0] e;
      e = {n == 7, 1'b0, 1'b0, 1'b1};
      total++;
      if ({commit, declined, steal, busy} !== e)
        $display("FAIL commit_seq n=%0d got %b want %b",
                 n, {commit, declined, steal, busy}, e);
      else pass_cnt++;
      if (n < 10) tick();
    end
    req = 1'b0;
    tick();
    total++;
    if ({commit, busy} !== 2'b00)
      $display("FAIL commit_drop got %b want 00", {commit, busy});
    else pass_cnt++;
  endtask

  task automatic test_decline;
    poke(5'd10, 5'd5, 3'd3);
    fire({5'd11, 5'd10, 5'd10, 5'd10},
         {5'd5, 5'd7, 5'd6, 5'd5}, 1'b1, 3'd2);
    for (int n = 1; n <= 10; n++) begin
      logic [3:0] e;
      e = {1'b0, n >= 7, 1'b0, 1'b1};
      total++;
      if ({commit, declined, steal, busy} !== e)
        $display("FAIL decline_seq n=%0d got %b want %b",
                 n, {commit, declined, steal, busy}, e);
      else pass_cnt++;
      if (n == 8) begin
        ph = {4{5'd2}}; pv = {5'd3, 5'd2, 5'd1, 5'd0};
      end
      if (n < 10) tick();
    end
    req = 1'b0;
    tick();
    total++;
    if ({declined, busy} !== 2'b00 || piece_count !== 16'd0)
      $display("FAIL decline_drop got %b pc=%0d want 00 pc=0",
               {declined, busy}, piece_count);
    else pass_cnt++;
    poke(5'd10, 5'd5, 3'd0);
  endtask

  task automatic test_oob(input logic [19:0] hs, input logic [19:0] vs,
                          input string nm);
    fire(hs, vs, 1'b1, 3'd4);
    for (int n = 1; n < 7; n++) tick();
    total++;
    if ({commit, declined, busy} !== 3'b011)
      $display("FAIL %s got %b want 011", nm, {commit, declined, busy});
    else pass_cnt++;
    req = 1'b0;
    tick();
    total++;
    if ({declined, busy} !== 2'b00)
      $display("FAIL %s_drop got %b want 00", nm, {declined, busy});
    else pass_cnt++;
  endtask

  task automatic test_lock;
    for (int k = 4; k <= 7; k++)
      exp_q.push_back({5'd19, 5'(k), 3'd5});
    fire({4{5'd20}}, {5'd7, 5'd6, 5'd5, 5'd4}, 1'b0, 3'd5);
    for (int n = 1; n <= 13; n++) begin
      logic [4:0] e;
      e = {1'b0, 1'b0, n >= 11, n == 11, 1'b1};
      total++;
      if ({commit, declined, steal, lock_pulse, busy} !== e ||
          piece_count !== ((n >= 11) ? 16'd1 : 16'd0))
        $display("FAIL lock_seq n=%0d got %b pc=%0d want %b",
                 n, {commit, declined, steal, lock_pulse, busy},
                 piece_count, e);
      else pass_cnt++;
      if (n < 13) tick();
    end
    req = 1'b0;
    tick();
    total++;
    if ({steal, busy} !== 2'b00)
      $display("FAIL steal_drop got %b want 00", {steal, busy});
    else pass_cnt++;
    for (int k = 4; k <= 7; k++) begin
      total++;
      if (mem[19][k] !== 3'd5)
        $display("FAIL lock_ram v=%0d got %0d want 5", k, mem[19][k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_lock_suppress;
    exp_q.push_back({5'd0, 5'd3, 3'd6});
    exp_q.push_back({5'd19, 5'd9, 3'd6});
    fire({5'd20, 5'd0, 5'd0, 5'd1},
         {5'd9, 5'd4, 5'd3, 5'd3}, 1'b0, 3'd6);
    for (int n = 1; n < 11; n++) tick();
    total++;
    if (piece_count !== 16'd2 || steal !== 1'b1 || exp_q.size() != 0)
      $display("FAIL suppress got pc=%0d steal=%b left=%0d want 2 1 0",
               piece_count, steal, exp_q.size());
    else pass_cnt++;
    req = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_lock;
    exp_q.push_back({5'd13, 5'd0, 3'd2});
    exp_q.push_back({5'd13, 5'd1, 3'd2});
    fire({5'd20, 5'd14, 5'd14, 5'd14},
         {5'd0, 5'd2, 5'd1, 5'd0}, 1'b0, 3'd2);
    for (int n = 1; n < 8; n++) tick();
    reset = 1'b0;
    tick();
    total++;
    if ({commit, declined, steal, we, lock_pulse, busy} !== 6'b0 ||
        piece_count !== 16'd0)
      $display("FAIL reset_lock got %b pc=%0d want zeros",
               {commit, declined, steal, we, lock_pulse, busy}, piece_count);
    else pass_cnt++;
    req = 1'b0; reset = 1'b1;
    tick();
    total++;
    if (mem[13][0] !== 3'd2 || mem[13][1] !== 3'd2 ||
        mem[13][2] !== 3'd0 || mem[19][0] !== 3'd0 || exp_q.size() != 0)
      $display("FAIL reset_lock_ram got %0d%0d%0d%0d left=%0d want 2200 0",
               mem[13][0], mem[13][1], mem[13][2], mem[19][0],
               exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_commit();
    test_decline();
    test_oob({4{5'd5}}, {5'd2, 5'd1, 5'd0, 5'd31}, "oob_v31");
    test_oob({5'd20, 5'd19, 5'd18, 5'd17}, {4{5'd3}}, "oob_h20");
    test_lock();
    test_lock_suppress();
    test_reset_in_lock();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/movement_arbiter.md
# movement_arbiter

Resolves every movement request from the falling-piece cell storage against the locked board: checks the four requested cell positions for bounds and occupancy, then answers commit, decline, or steal. On a blocked natural fall it writes the piece into the board RAM one row up (lock) before answering steal. It is the only board-RAM writer and sits between cell storage, board RAM and score logic.

## Interface
- BOARD_H, 20, rows along the fall (h) axis; valid h is 0..BOARD_H-1
- BOARD_W, 10, columns along the lateral (v) axis; valid v is 0..BOARD_W-1
- clk  in  1  clock
- reset  in  1  synchronous, active-low; clock clk
- movement_request  in  1  level request from cell storage
- movement_intent  in  1  0 = natural fall (gametick), 1 = player move/rotate
- P1blk_v..P4blk_v, P1blk_h..P4blk_h  in  5 each  requested cell coordinates
- volatile_blk_color  in  3  piece colour; nonzero
- movement_commit  out  1  one-cycle accept pulse
- movement_declined  out  1  level; held until request drops
- movement_steal  out  1  level; held until request drops
- board_raddr_h / board_raddr_v  out  5/5  board read address
- board_rdata  in  3  colour at read address, 1-cycle latency; 0 = empty
- board_we  out  1  board write enable
- board_waddr_h / board_waddr_v / board_wdata  out  5/5/3  board write port
- lock_pulse  out  1  one cycle when a lock completes
- piece_count  out  16  locked-piece counter, wraps
- arb_busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, CHECK, DECIDE, COMMIT, DECLINE, LOCK, STEAL, WAIT_DROP.
- IDLE: on sampled movement_request=1, latch 8 coordinates, intent and colour; per cell compute oob_k = (h>=BOARD_H)|(v>=BOARD_W). Wrapped 0-1 = 31 counts as out of bounds. Go CHECK with idx=0.
- CHECK: 5 cycles. In cycle k (0..3) drive raddr = cell k. In cycle k+1, OR (board_rdata!=0)&!oob_k into hit. The 5th cycle only collects data. Then go DECIDE.
- DECIDE: blocked = hit | any oob_k.
  - Not blocked: go COMMIT.
  - Blocked with intent=1: go DECLINE.
  - Blocked with intent=0: go LOCK.
- COMMIT: movement_commit=1 for exactly one cycle, then WAIT_DROP.
- DECLINE: movement_declined=1 until movement_request is sampled 0. Deassert on the next edge, go IDLE.
- LOCK: 4 cycles. Cycle k writes cell k at (h_k-1, v_k) with the latched colour. board_we is suppressed for that cell if h_k=0 or the shifted cell is out of bounds. Then increment piece_count, pulse lock_pulse, go STEAL.
- STEAL: movement_steal=1 until movement_request is sampled 0, then deassert and go IDLE.
- WAIT_DROP: wait for movement_request=0, then go IDLE. This prevents the still-high request from being re-sampled as a new one.
- Latched values are used throughout. Coordinate changes while not in IDLE are ignored.
- A request is never sampled outside IDLE.
- The piece's own cells are never in board RAM, so there is no self-collision.

## Timing
- Reset values:
  - Outputs 0: commit, declined, steal, board_we, lock_pulse, arb_busy.
  - Addresses and data 0; piece_count 0; state IDLE.
- Reset applies mid-operation. Writes already issued in LOCK remain in RAM; no rollback.
- Request sampled at edge E.
  - CHECK occupies cycles E+1..E+5 and DECIDE E+6.
  - movement_commit is high in cycle E+7.
  - movement_declined rises at E+7.
- Lock path: writes in cycles E+7..E+10; lock_pulse and piece_count update at E+11; movement_steal rises at E+11.
- Declined/steal fall one edge after request is sampled low. Minimum hold is 1 cycle if the request is already low.
- All outputs are registered. No combinational path from input to output.

## Test plan
- Empty board, request intent=0, cells (6,5),(7,5),(8,5),(9,5) -> commit pulse at E+7, no board_we, back to IDLE after request drops.
- Board (10,5)=3, intent=1 request including (10,5) -> declined held high until request low, no writes, piece_count unchanged.
- Intent=1 request with v=31 (wrapped) on an empty board -> declined; intent=1 request with h=20 -> declined.
- Intent=0 request with cells at h=20 (floor), colour 5, v=4..7 -> four writes at h=19, v=4..7, wdata=5; lock_pulse; piece_count=1; steal held until request low.
- Commit, then request kept high 3 more cycles -> exactly one commit; no second check until request has been low.
- Reset asserted during LOCK after 2 writes -> all outputs 0 next cycle, state IDLE, piece_count 0, 2 cells remain written.
